// File: rtl/bsg_comm_link_credit_tx_pkg.sv
// Shared types for the credit-based comm-link transmit stage.
// Holds the shifter state encoding used by the top level.
package bsg_comm_link_credit_tx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } tx_state_e;

endpackage : bsg_comm_link_credit_tx_pkg

// File: rtl/bsg_comm_link_credit_tx_counter.sv
// Saturating credit counter: one credit spent per launch, token_decimation_p
// returned per token pulse, sticky overflow flag, async reset to full credits.
module bsg_comm_link_credit_counter #(
   parameter int unsigned credits_p          = 16,
   parameter int unsigned token_decimation_p = 4
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             dec_i,
   input  logic                             inc_i,
   output logic [$clog2(credits_p+1)-1:0]   credits_o,
   output logic                             error_o
);

   localparam int unsigned cred_w_lp = $clog2(credits_p+1);
   localparam logic [cred_w_lp:0] tdp_lp = token_decimation_p[cred_w_lp:0];
   localparam logic [cred_w_lp:0] cap_lp = credits_p[cred_w_lp:0];

   logic [cred_w_lp-1:0] credits_q, credits_d;
   logic                 error_q, error_d;
   logic [cred_w_lp:0]   sum;

   // One extra bit of headroom so a token at full credits is seen as overflow.
   always_comb begin
      sum       = {1'b0, credits_q} + (inc_i ? tdp_lp : '0)
                - {{cred_w_lp{1'b0}}, dec_i};
      credits_d = sum[cred_w_lp-1:0];
      error_d   = error_q;
      if (sum > cap_lp) begin
         credits_d = cap_lp[cred_w_lp-1:0];
         error_d   = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         credits_q <= cap_lp[cred_w_lp-1:0];
         error_q   <= 1'b0;
      end else begin
         credits_q <= credits_d;
         error_q   <= error_d;
      end
   end

   assign credits_o = credits_q;
   assign error_o   = error_q;

endmodule : bsg_comm_link_credit_counter

// File: rtl/bsg_comm_link_credit_tx.sv
// Core-side transmit stage: holds one word, serializes it LSB beat first onto
// the channel, and gates each word launch on available credits.
module bsg_comm_link_credit_tx
   import bsg_comm_link_credit_tx_pkg::*;
#(
   parameter int unsigned channel_width_p    = 8,
   parameter int unsigned word_width_p       = 32,
   parameter int unsigned credits_p          = 16,
   parameter int unsigned token_decimation_p = 4
) (
   input  logic                             core_clk_i,
   input  logic                             async_reset_i,
   input  logic [word_width_p-1:0]          data_i,
   input  logic                             v_i,
   output logic                             ready_o,
   input  logic                             token_i,
   output logic                             valid_o,
   output logic [channel_width_p-1:0]       data_o,
   output logic [$clog2(credits_p+1)-1:0]   credits_o,
   output logic                             error_o
);

   localparam int unsigned beats_lp  = word_width_p / channel_width_p;
   localparam int unsigned beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
   localparam int unsigned last_lp   = beats_lp - 1;

   if (word_width_p % channel_width_p != 0) begin : g_bad_word_width
      $error("word_width_p must be a multiple of channel_width_p");
   end
   if (beats_lp < 2) begin : g_bad_beats
      $error("at least two beats per word are required");
   end
   if (token_decimation_p > credits_p) begin : g_bad_decimation
      $error("token_decimation_p must not exceed credits_p");
   end

   tx_state_e                 state_q, state_d;
   logic [word_width_p-1:0]   hold_q, hold_d;
   logic                      hold_v_q, hold_v_d;
   logic [word_width_p-1:0]   shift_q, shift_d;
   logic [beat_w_lp-1:0]      beat_q, beat_d;
   logic                      last_beat;
   logic                      launch;
   logic                      accept;

   assign last_beat = (state_q == ST_SEND) && (beat_q == last_lp[beat_w_lp-1:0]);
   assign launch    = hold_v_q && (credits_o != '0)
                    && ((state_q == ST_IDLE) || last_beat);
   assign accept    = v_i && ready_o;

   // State register
   always_ff @(posedge core_clk_i or posedge async_reset_i) begin
      if (async_reset_i) state_q <= ST_IDLE;
      else               state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (launch) state_d = ST_SEND;
         ST_SEND: if (last_beat && !launch) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      valid_o = (state_q == ST_SEND);
      data_o  = shift_q[channel_width_p-1:0];
      ready_o = ~hold_v_q;
   end

   // A launch and a new accept never coincide: launch needs a full holding
   // register, accept needs an empty one.
   always_comb begin
      hold_d   = hold_q;
      hold_v_d = hold_v_q;
      shift_d  = shift_q;
      beat_d   = beat_q;
      if (launch) begin
         shift_d  = hold_q;
         beat_d   = '0;
         hold_v_d = 1'b0;
      end else if (state_q == ST_SEND) begin
         shift_d = shift_q >> channel_width_p;
         beat_d  = last_beat ? '0 : beat_q + 1'b1;
      end
      if (accept) begin
         hold_d   = data_i;
         hold_v_d = 1'b1;
      end
   end

   always_ff @(posedge core_clk_i or posedge async_reset_i) begin
      if (async_reset_i) begin
         hold_q   <= '0;
         hold_v_q <= 1'b0;
         shift_q  <= '0;
         beat_q   <= '0;
      end else begin
         hold_q   <= hold_d;
         hold_v_q <= hold_v_d;
         shift_q  <= shift_d;
         beat_q   <= beat_d;
      end
   end

   bsg_comm_link_credit_counter #(
      .credits_p          (credits_p),
      .token_decimation_p (token_decimation_p)
   ) u_credit_counter (
      .clk_i     (core_clk_i),
      .reset_i   (async_reset_i),
      .dec_i     (launch),
      .inc_i     (token_i),
      .credits_o (credits_o),
      .error_o   (error_o)
   );

endmodule : bsg_comm_link_credit_tx

// File: tb/tb_bsg_comm_link_credit_tx.sv
// Scoreboard bench for bsg_comm_link_credit_tx: default 32/8 configuration
// against a count-based reference model, plus a 16/8, 2-credit instance.
module tb_bsg_comm_link_credit_tx;

   localparam int BEATS = 4;
   localparam int CRED  = 16;
   localparam int TD    = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [31:0] data_i  = '0;
   logic        v_i     = 1'b0;
   logic        token_i = 1'b0;
   logic        ready_o, valid_o, error_o;
   logic [7:0]  data_o;
   logic [4:0]  credits_o;

   logic [15:0] w_data  = '0;
   logic        w_v     = 1'b0;
   logic        w_tok   = 1'b0;
   logic        w_ready, w_valid, w_err;
   logic [7:0]  w_dout;
   logic [1:0]  w_cred;

   bsg_comm_link_credit_tx #(
      .channel_width_p(8), .word_width_p(32), .credits_p(16), .token_decimation_p(4)
   ) dut (
      .core_clk_i(clk), .async_reset_i(rst), .data_i(data_i), .v_i(v_i),
      .ready_o(ready_o), .token_i(token_i), .valid_o(valid_o), .data_o(data_o),
      .credits_o(credits_o), .error_o(error_o)
   );

   bsg_comm_link_credit_tx #(
      .channel_width_p(8), .word_width_p(16), .credits_p(2), .token_decimation_p(1)
   ) dut_w (
      .core_clk_i(clk), .async_reset_i(rst), .data_i(w_data), .v_i(w_v),
      .ready_o(w_ready), .token_i(w_tok), .valid_o(w_valid), .data_o(w_dout),
      .credits_o(w_cred), .error_o(w_err)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words held (0/1), beats left in the current word,
   // credit balance and sticky error. Expected bytes queued at acceptance.
   bit        m_hold = 0;
   int        m_rem  = 0;
   int        m_cred = CRED;
   bit        m_err  = 0;
   logic [7:0] exp_q[$];
   logic [7:0] w_exp[$];

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_hold = 0; m_rem = 0; m_cred = CRED; m_err = 0;
         exp_q.delete();
      end else begin
         bit launch, acc;
         launch = m_hold && (m_cred > 0) && (m_rem <= 1);
         acc    = v_i && !m_hold;
         if (m_rem > 0) m_rem--;
         if (launch) begin
            m_hold = 0; m_rem = BEATS; m_cred--;
         end
         if (token_i) m_cred += TD;
         if (m_cred > CRED) begin
            m_cred = CRED; m_err = 1;
         end
         if (acc) begin
            m_hold = 1;
            for (int i = 0; i < BEATS; i++) exp_q.push_back(8'(data_i >> (8*i)));
         end
      end
   end

   // Monitor: compares every cycle away from the active edge.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         chk("valid_o", valid_o, m_rem != 0);
         chk("ready_o", ready_o, !m_hold);
         chk("credits_o", credits_o, m_cred);
         chk("error_o", error_o, m_err);
         if (valid_o) begin
            if (exp_q.size() == 0) chk("stale_beat", 1, 0);
            else chk("data_o", data_o, exp_q.pop_front());
         end
         if (w_valid) begin
            if (w_exp.size() == 0) chk("w_stale_beat", 1, 0);
            else chk("w_data_o", w_dout, w_exp.pop_front());
         end
      end
   end

   task automatic send_word(input logic [31:0] w);
      int n = 0;
      bit done = 0;
      v_i = 1'b1; data_i = w;
      while (!done && n < 200) begin
         @(negedge clk); done = ready_o;
         @(posedge clk); #1; n++;
      end
      v_i = 1'b0;
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || m_rem != 0 || m_hold) && n < 400) begin
         @(posedge clk); n++;
      end
      #1;
      chk("drain_done", exp_q.size(), 0);
   endtask

   task automatic pulse_token();
      token_i = 1'b1;
      @(posedge clk); #1;
      token_i = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_valid", valid_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_credits", credits_o, CRED);
      chk("rst_error", error_o, 0);
      chk("rst_ready", ready_o, 1);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send_wide(input logic [15:0] w);
      int n = 0;
      bit done = 0;
      w_v = 1'b1; w_data = w;
      while (!done && n < 100) begin
         @(negedge clk); done = w_ready;
         @(posedge clk); #1; n++;
      end
      w_v = 1'b0;
      if (done) begin
         w_exp.push_back(w[7:0]);
         w_exp.push_back(w[15:8]);
      end else chk("w_send_timeout", 0, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();

      // Single word: launch at end of cycle 1, beats in cycles 2..5.
      send_word(32'hDDCCBBAA);
      chk("single_cred_c1", credits_o, 16);
      @(posedge clk); #1;
      chk("single_cred_c2", credits_o, 15);
      chk("single_valid_c2", valid_o, 1);
      chk("single_beat0", data_o, 8'hAA);
      drain();

      // Streaming until credits run out, then recover with one token.
      do_reset();
      for (int i = 0; i < 17; i++) send_word(32'h1000_0000 + 32'(i) * 32'h0101_0101);
      v_i = 1'b1; data_i = 32'hA5A5_0018;
      repeat (40) @(posedge clk);
      #1;
      v_i = 1'b0;
      chk("stall_credits", credits_o, 0);
      chk("stall_ready", ready_o, 0);
      chk("stall_valid", valid_o, 0);
      pulse_token();
      chk("token_credits", credits_o, 4);
      send_word(32'hA5A5_0018);
      send_word(32'h1234_5678);
      send_word(32'h9ABC_DEF0);
      drain();

      // Token on the same edge as a launch with 10 credits.
      do_reset();
      for (int i = 0; i < 6; i++) send_word($urandom);
      drain();
      chk("simul_pre", credits_o, 10);
      v_i = 1'b1; data_i = 32'hCAFE_F00D;
      @(negedge clk);
      chk("simul_ready", ready_o, 1);
      @(posedge clk); #1;
      v_i = 1'b0; token_i = 1'b1;
      @(posedge clk); #1;
      token_i = 1'b0;
      chk("simul_credits", credits_o, 13);
      drain();

      // Overflow is sticky until reset.
      do_reset();
      send_word(32'h0000_0001);
      send_word(32'h0000_0002);
      drain();
      chk("ovf_pre", credits_o, 14);
      pulse_token();
      chk("ovf_credits", credits_o, 16);
      chk("ovf_error", error_o, 1);
      send_word(32'h0000_0003);
      drain();
      chk("ovf_sticky", error_o, 1);

      // Reset in the middle of a word with a second word held.
      do_reset();
      chk("post_ovf_error", error_o, 0);
      send_word(32'h4433_2211);
      send_word(32'h8877_6655);
      @(posedge clk); #1;
      chk("mid_valid_pre", valid_o, 1);
      rst = 1'b1;
      #1;
      chk("mid_valid", valid_o, 0);
      chk("mid_data", data_o, 0);
      chk("mid_credits", credits_o, CRED);
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b0;
      chk("mid_ready", ready_o, 1);
      repeat (12) @(posedge clk);
      #1;
      chk("mid_no_stale", valid_o, 0);

      // Randomized traffic with random tokens.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         v_i     = ($urandom_range(0, 3) != 0);
         data_i  = $urandom;
         token_i = ($urandom_range(0, 9) == 0);
         @(posedge clk); #1;
      end
      v_i = 1'b0; token_i = 1'b0;
      pulse_token();
      repeat (3) @(posedge clk);
      #1;
      pulse_token();
      drain();

      // Narrow-word configuration: third word waits for a token.
      do_reset();
      send_wide(16'hB2B1);
      send_wide(16'hC2C1);
      send_wide(16'hD2D1);
      repeat (20) @(posedge clk);
      #1;
      chk("w_stall_pending", w_exp.size(), 2);
      chk("w_stall_credits", w_cred, 0);
      chk("w_stall_ready", w_ready, 0);
      w_tok = 1'b1;
      @(posedge clk); #1;
      w_tok = 1'b0;
      chk("w_token_credits", w_cred, 1);
      repeat (10) @(posedge clk);
      #1;
      chk("w_done_pending", w_exp.size(), 0);
      chk("w_done_credits", w_cred, 0);
      chk("w_error", w_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_bsg_comm_link_credit_tx

// File: doc/bsg_comm_link_credit_tx.md
# bsg_comm_link_credit_tx

Core-side transmit stage feeding one outbound comm-link channel of the chip frame. It accepts 32-bit words from the core over a valid/ready handshake and serializes each word into byte beats on the channel's 8-bit output. Flow control is credit-based: credits are returned by token pulses that have already been synchronized into the core clock domain. There is one instance per outbound channel, and it sits directly upstream of the channel's output pads.

## Interface
Parameters:
- `channel_width_p`, default 8: bits per channel beat.
- `word_width_p`, default 32: core word width. Must be a multiple of `channel_width_p`, with at least 2 beats per word.
- `credits_p`, default 16: initial and maximum credit count, in words.
- `token_decimation_p`, default 4: credits returned per `token_i` pulse.

Ports:
- `core_clk_i`, in, 1: the single clock.
- `async_reset_i`, in, 1: reset, asynchronous, active-high.
- `data_i`, in, `word_width_p`: word from the core.
- `v_i`, in, 1: `data_i` is valid.
- `ready_o`, out, 1: the block can accept a word this cycle.
- `token_i`, in, 1: one-cycle pulse, already synchronized; each pulse returns `token_decimation_p` credits.
- `valid_o`, out, 1: a channel beat is present this cycle.
- `data_o`, out, `channel_width_p`: channel beat.
- `credits_o`, out, `$clog2(credits_p+1)`: current credit count.
- `error_o`, out, 1: sticky credit-overflow flag.

## Operation
- Local constant `beats_lp = word_width_p/channel_width_p`.
- Holding register `hold_r`/`hold_v_r`:
  - `ready_o = ~hold_v_r` (combinational).
  - `v_i & ready_o` loads `hold_r` and sets `hold_v_r`.
- Shifter, with states IDLE and SEND:
  - **Launch:** when `hold_v_r`, credits > 0, and (IDLE, or SEND on the last beat), transfer `hold_r` into the shift register on that edge. This clears `hold_v_r`, decrements credits by 1, sets the beat counter to 0, and enters or stays in SEND.
  - **SEND, per cycle:** `valid_o = 1` and `data_o` = lowest `channel_width_p` bits of the shift register. At each edge shift right by `channel_width_p` and increment the beat counter.
  - **Beat order:** LSB byte first.
  - **Leaving SEND:** after the last beat (`beat == beats_lp-1`), go to IDLE unless a launch occurs on that same edge.
- Credits: `credits_next = credits - launch + (token_i ? token_decimation_p : 0)`.
  - A simultaneous launch and token yields the net of both.
  - If `credits_next > credits_p`, saturate to `credits_p` and set `error_o`. `error_o` stays set until reset.
- Zero credits:
  - A held word waits; `valid_o` stays 0 after the current word finishes.
  - `ready_o` stays 0 while `hold_v_r` is set.
- Reset values:
  - `valid_o=0`, `data_o=0`, `credits_o=credits_p`, `error_o=0`, `hold_v_r=0`.
  - `ready_o=1`, but inputs are ignored while `async_reset_i` is high.
- Reset mid-word: outputs clear immediately (asynchronously); the partial word and the held word are dropped; credits return to `credits_p`.

## Timing
- Word accepted in cycle 0 with the shifter idle and credits > 0:
  - Launch on the edge ending cycle 1.
  - Beats appear in cycles 2 .. 1+`beats_lp`.
- Sustained throughput is one word per `beats_lp` cycles with no gaps.
  - This requires the next word to be in `hold_r` by the last beat of the current word, and credits > 0.
- Latency from `token_i` to launch eligibility is 1 cycle: credits update on the `token_i` edge.
- `valid_o`, `data_o`, `credits_o` and `error_o` are registered. `ready_o` is combinational from `hold_v_r` only; there is no path from `v_i`.

## Structure
- No shared-package additions. `beats_lp` and the counter widths are local constants.
- Parameter legality checks go in an initial block: `word_width_p % channel_width_p == 0`, `beats_lp >= 2`, `token_decimation_p <= credits_p`.
- One sub-module, `bsg_comm_link_credit_counter`:
  - Inputs: decrement, increment-by-`token_decimation_p`.
  - Behaviour: saturating at `credits_p`, with a sticky overflow flag and async reset to `credits_p`.
- The top level holds the holding register, shifter and beat counter.

## Test plan
- **Single word:** after reset, send `data_i=32'hDDCCBBAA` in cycle 0 → `valid_o` high in cycles 2-5 with `data_o` = AA, BB, CC, DD; `credits_o` drops 16→15 at the end of cycle 1.
- **Streaming:** 20 back-to-back words, no tokens → exactly 16 words emitted gap-free (64 beats); `valid_o` then stays 0 and `ready_o` stays 0 with word 17 held. One `token_i` pulse → `credits_o`=4, word 17 launches next edge, word 18 follows gap-free.
- **Simultaneous events:** `token_i` pulse on the same edge as a launch with credits=10 → `credits_o`=13.
- **Overflow:** `token_i` pulse at credits=14 → `credits_o`=16 and `error_o`=1; `error_o` persists through further traffic until reset.
- **Reset mid-word:** assert `async_reset_i` during beat 2 of a word with a second word held → `valid_o`=0 immediately; after release, `credits_o`=16, `ready_o`=1, and no stale beats appear.
- **Wide configuration:** `word_width_p=16`, `channel_width_p=8`, `credits_p=2` → two-beat words; a third word stalls until a token arrives.
